sprite_write_shadow: RTL and testbench

- Sits directly upstream of the sprite datapath, between the CPU write bus and the datapath's sprite RAM write port.
- Captures CPU writes to sprite attribute addresses into a coalescing shadow register file with per-entry dirty bits.
- Replays only the dirty entries, in a fixed order, at the start of vertical blank, so sprite position/number/palette never change mid-frame (no tearing).
- Non-sprite writes are ignored.

---
 rtl/sprite_write_shadow.sv | 138 +++++++++++++
 tb/tb_sprite_write_shadow.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_write_shadow.sv
// Coalescing shadow of the CPU's sprite attribute writes; dirty entries are
// replayed in ascending index order at the start of vertical blank.
module sprite_write_shadow #(
  parameter int VBLANK_ROW  = 272,
  parameter int NUM_ENTRIES = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  row,
  input  logic [9:0]  col,
  input  logic        cpu_wr_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        spr_wr_en,
  output logic [15:0] spr_addr,
  output logic [7:0]  spr_din,
  output logic        commit_busy,
  output logic        commit_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_ENTRIES - 1);

  function automatic logic addr_hit(input logic [15:0] a);
    return (a[15:4] == 12'h4FF) || (a[15:4] == 12'h506) || (a == 16'h5003);
  endfunction

  function automatic logic [5:0] addr_to_idx(input logic [15:0] a);
    if (a[15:4] == 12'h4FF)      return {2'b00, a[3:0]};
    else if (a[15:4] == 12'h506) return {2'b01, a[3:0]};
    else                         return 6'd32;
  endfunction

  function automatic logic [15:0] idx_to_addr(input logic [5:0] i);
    if (i[5])      return 16'h5003;
    else if (i[4]) return {12'h506, i[3:0]};
    else           return {12'h4FF, i[3:0]};
  endfunction

  state_t                 state_q, state_d;
  logic [5:0]             idx_q, idx_d;
  logic [7:0]             shadow_q [NUM_ENTRIES];
  logic [7:0]             shadow_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] dirty_q, dirty_d;
  logic                   trig_q, trig_d;
  logic                   spr_wr_en_q, spr_wr_en_d;
  logic [15:0]            spr_addr_q, spr_addr_d;
  logic [7:0]             spr_din_q, spr_din_d;
  logic                   commit_done_q, commit_done_d;

  logic       trig;
  logic       trig_rise;
  logic       wr_hit;
  logic [5:0] wr_idx;
  logic       bypass;

  assign trig      = (row == VBLANK_ROW[8:0]) && (col == 10'd0);
  assign trig_rise = trig && !trig_q;
  assign trig_d    = trig;
  assign wr_hit    = cpu_wr_en && addr_hit(cpu_addr);
  assign wr_idx    = addr_to_idx(cpu_addr);
  // A write landing on the entry being visited is forwarded straight out.
  assign bypass    = (state_q == SCAN) && wr_hit && (wr_idx == idx_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    dirty_d       = dirty_q;
    spr_wr_en_d   = 1'b0;
    spr_addr_d    = spr_addr_q;
    spr_din_d     = spr_din_q;
    commit_done_d = 1'b0;

    if (wr_hit) begin
      shadow_d[wr_idx] = cpu_din;
      dirty_d[wr_idx]  = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trig_rise) begin
          state_d = SCAN;
          idx_d   = 6'd0;
        end
      end
      SCAN: begin
        if (dirty_q[idx_q] || bypass) begin
          spr_wr_en_d = 1'b1;
          spr_addr_d  = idx_to_addr(idx_q);
          spr_din_d   = bypass ? cpu_din : shadow_q[idx_q];
        end
        // Clearing after capture also drops the dirty bit a bypassed write set.
        dirty_d[idx_q] = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d       = IDLE;
          idx_d         = 6'd0;
          commit_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= 6'd0;
      dirty_q       <= '0;
      trig_q        <= 1'b0;
      spr_wr_en_q   <= 1'b0;
      spr_addr_q    <= 16'h0000;
      spr_din_q     <= 8'h00;
      commit_done_q <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) shadow_q[i] <= 8'h00;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dirty_q       <= dirty_d;
      trig_q        <= trig_d;
      spr_wr_en_q   <= spr_wr_en_d;
      spr_addr_q    <= spr_addr_d;
      spr_din_q     <= spr_din_d;
      commit_done_q <= commit_done_d;
      shadow_q      <= shadow_d;
    end
  end

  assign spr_wr_en   = spr_wr_en_q;
  assign spr_addr    = spr_addr_q;
  assign spr_din     = spr_din_q;
  assign commit_busy = (state_q == SCAN);
  assign commit_done = commit_done_q;

endmodule

// File: tb/tb_sprite_write_shadow.sv
// Bench for sprite_write_shadow: table-driven address map vectors, directed
// multi-cycle sequences and random frames checked against a reference model.
module tb_sprite_write_shadow;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  row;
  logic [9:0]  col;
  logic        cpu_wr_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        spr_wr_en;
  logic [15:0] spr_addr;
  logic [7:0]  spr_din;
  logic        commit_busy;
  logic        commit_done;

  sprite_write_shadow dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .spr_wr_en(spr_wr_en), .spr_addr(spr_addr), .spr_din(spr_din),
    .commit_busy(commit_busy), .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] addr_tab [33];
  logic [7:0]  m_shadow [33];
  bit          m_dirty  [33];
  bit          m_scan;
  int          m_pos;
  bit          m_prev_trig;
  logic        e_wr, e_done;
  logic [15:0] e_addr;
  logic [7:0]  e_din;

  function automatic int lookup(input logic [15:0] a);
    for (int i = 0; i < 33; i++) if (addr_tab[i] == a) return i;
    return -1;
  endfunction

  function automatic void model_step(input logic r, input logic [8:0] rw, input logic [9:0] cl,
                                     input logic we, input logic [15:0] a, input logic [7:0] d);
    bit trig, rise, hit_now;
    int widx;
    if (r) begin
      for (int i = 0; i < 33; i++) begin m_shadow[i] = 8'h00; m_dirty[i] = 0; end
      m_scan = 0; m_pos = 0; m_prev_trig = 0;
      e_wr = 0; e_done = 0; e_addr = 16'h0; e_din = 8'h0;
      return;
    end
    trig = (rw == 9'd272) && (cl == 10'd0);
    rise = trig && !m_prev_trig;
    m_prev_trig = trig;
    widx = we ? lookup(a) : -1;
    e_wr = 0; e_done = 0;
    hit_now = m_scan && (widx == m_pos);
    if (m_scan && (m_dirty[m_pos] || hit_now)) begin
      e_wr = 1;
      e_addr = addr_tab[m_pos];
      e_din = hit_now ? d : m_shadow[m_pos];
    end
    if (m_scan) m_dirty[m_pos] = 0;
    if (widx >= 0) begin
      m_shadow[widx] = d;
      if (!hit_now) m_dirty[widx] = 1;
    end
    if (m_scan) begin
      if (m_pos == 32) begin m_scan = 0; e_done = 1; end
      else m_pos++;
    end else if (rise) begin
      m_scan = 1; m_pos = 0;
    end
  endfunction

  // ---------------- stepping and frame bookkeeping ----------------
  typedef struct { int rel; logic [15:0] addr; logic [7:0] din; } em_t;
  em_t em_q[$];
  int  s = 0;
  int  trig_s = 0;
  int  busy_cnt, done_cnt, done_rel;

  task automatic step(input logic r, input logic [8:0] rw, input logic [9:0] cl,
                      input logic we, input logic [15:0] a, input logic [7:0] d);
    int n;
    rst = r; row = rw; col = cl; cpu_wr_en = we; cpu_addr = a; cpu_din = d;
    model_step(r, rw, cl, we, a, d);
    n = s;
    @(posedge clk); #1;
    s = n + 1;
    chk($sformatf("cycle%0d busy,done,wr,addr,din", s),
        {35'd0, commit_busy, commit_done, spr_wr_en, spr_addr, spr_din},
        {35'd0, m_scan, e_done, e_wr, e_addr, e_din});
    if (spr_wr_en) em_q.push_back('{rel: n + 1 - trig_s, addr: spr_addr, din: spr_din});
    if (commit_busy) busy_cnt++;
    if (commit_done) begin done_cnt++; done_rel = n + 1 - trig_s; end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    step(1'b0, 9'd100, 10'd7, 1'b1, a, d);
  endtask

  // Trigger at relative step 0, then 40 blanking steps; optional writes/reset.
  task automatic run_frame(input int s1, input logic [15:0] a1, input logic [7:0] d1,
                           input int s2, input logic [15:0] a2, input logic [7:0] d2,
                           input int rst_at);
    em_q.delete(); busy_cnt = 0; done_cnt = 0; done_rel = 0;
    trig_s = s;
    step(1'b0, 9'd272, 10'd0, 1'b0, 16'h0, 8'h0);
    for (int o = 1; o <= 40; o++) begin
      if (o == s1)      step(o == rst_at, 9'd0, 10'd5, 1'b1, a1, d1);
      else if (o == s2) step(o == rst_at, 9'd0, 10'd5, 1'b1, a2, d2);
      else              step(o == rst_at, 9'd0, 10'd5, 1'b0, 16'h0, 8'h0);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 9) < 7) return addr_tab[$urandom_range(0, 32)];
    return 16'($urandom);
  endfunction

  typedef struct { logic [15:0] addr; logic [7:0] din; int hit; int rel; } vec_t;
  vec_t vecs[10];

  initial begin
    for (int i = 0; i < 16; i++) addr_tab[i] = 16'h4FF0 + 16'(i);
    for (int i = 16; i < 32; i++) addr_tab[i] = 16'h5060 + 16'(i - 16);
    addr_tab[32] = 16'h5003;

    vecs[0] = '{16'h4FF0, 8'hA1, 1, 2};
    vecs[1] = '{16'h4FFF, 8'hA2, 1, 17};
    vecs[2] = '{16'h5060, 8'hA3, 1, 18};
    vecs[3] = '{16'h506F, 8'hA4, 1, 33};
    vecs[4] = '{16'h5003, 8'hA5, 1, 34};
    vecs[5] = '{16'h4FEF, 8'hB1, 0, 0};
    vecs[6] = '{16'h5070, 8'hB2, 0, 0};
    vecs[7] = '{16'h5002, 8'hB3, 0, 0};
    vecs[8] = '{16'h505F, 8'hB4, 0, 0};
    vecs[9] = '{16'h1234, 8'hB5, 0, 0};

    // Reset state
    step(1'b1, 9'd0, 10'd5, 1'b0, 16'h0, 8'h0);
    step(1'b1, 9'd0, 10'd5, 1'b0, 16'h0, 8'h0);
    chk("reset outputs", {spr_wr_en, spr_addr, spr_din, commit_busy, commit_done}, 27'd0);

    // Idle frame: busy for 33 cycles, no writes, done at T+34
    run_frame(-1, 16'h0, 8'h0, -1, 16'h0, 8'h0, -1);
    chk("idle busy cycles", busy_cnt, 33);
    chk("idle emissions", em_q.size(), 0);
    chk("idle done count", done_cnt, 1);
    chk("idle done cycle", done_rel, 34);

    // Coalescing
    cpu_write(16'h5060, 8'h40);
    cpu_write(16'h5060, 8'h55);
    cpu_write(16'h4FF1, 8'h07);
    chk("no emission before trigger", em_q.size(), 0);
    run_frame(-1, 16'h0, 8'h0, -1, 16'h0, 8'h0, -1);
    chk("coalesce count", em_q.size(), 2);
    if (em_q.size() == 2) begin
      chk("coalesce first", {em_q[0].rel, em_q[0].addr, em_q[0].din}, {32'd3, 16'h4FF1, 8'h07});
      chk("coalesce second", {em_q[1].rel, em_q[1].addr, em_q[1].din}, {32'd18, 16'h5060, 8'h55});
    end

    // Flip entry plus unmapped write
    cpu_write(16'h5003, 8'h01);
    cpu_write(16'h1234, 8'hAA);
    run_frame(-1, 16'h0, 8'h0, -1, 16'h0, 8'h0, -1);
    chk("flip count", em_q.size(), 1);
    if (em_q.size() == 1)
      chk("flip emission", {em_q[0].rel, em_q[0].addr, em_q[0].din}, {32'd34, 16'h5003, 8'h01});
    chk("flip done cycle", done_rel, 34);

    // Address map table
    for (int v = 0; v < 10; v++) begin
      cpu_write(vecs[v].addr, vecs[v].din);
      run_frame(-1, 16'h0, 8'h0, -1, 16'h0, 8'h0, -1);
      chk($sformatf("map %h count", vecs[v].addr), em_q.size(), vecs[v].hit);
      if (em_q.size() == 1)
        chk($sformatf("map %h emission", vecs[v].addr), {em_q[0].rel, em_q[0].addr, em_q[0].din},
            {vecs[v].rel, vecs[v].addr, vecs[v].din});
    end

    // Mid-scan writes: idx 20 visited at step 21; idx 17 passed, idx 24 ahead
    run_frame(21, 16'h5061, 8'h33, 22, 16'h5068, 8'h44, -1);
    chk("midscan count", em_q.size(), 1);
    if (em_q.size() == 1)
      chk("midscan ahead", {em_q[0].rel, em_q[0].addr, em_q[0].din}, {32'd26, 16'h5068, 8'h44});
    run_frame(-1, 16'h0, 8'h0, -1, 16'h0, 8'h0, -1);
    chk("midscan next count", em_q.size(), 1);
    if (em_q.size() == 1)
      chk("midscan passed", {em_q[0].rel, em_q[0].addr, em_q[0].din}, {32'd19, 16'h5061, 8'h33});

    // Bypass: write idx 18 in the step it is visited
    cpu_write(16'h5062, 8'h10);
    run_frame(19, 16'h5062, 8'h9C, -1, 16'h0, 8'h0, -1);
    chk("bypass count", em_q.size(), 1);
    if (em_q.size() == 1)
      chk("bypass emission", {em_q[0].rel, em_q[0].addr, em_q[0].din}, {32'd20, 16'h5062, 8'h9C});
    run_frame(-1, 16'h0, 8'h0, -1, 16'h0, 8'h0, -1);
    chk("bypass next frame", em_q.size(), 0);

    // Reset mid-scan discards pending entries
    cpu_write(16'h4FFC, 8'h11);
    cpu_write(16'h506E, 8'h22);
    run_frame(-1, 16'h0, 8'h0, -1, 16'h0, 8'h0, 10);
    chk("reset scan emissions", em_q.size(), 0);
    chk("post reset outputs", {spr_wr_en, spr_addr, spr_din, commit_busy, commit_done}, 27'd0);
    run_frame(-1, 16'h0, 8'h0, -1, 16'h0, 8'h0, -1);
    chk("after reset frame", em_q.size(), 0);

    // Random frames against the model
    for (int f = 0; f < 8; f++) begin
      int nw;
      nw = $urandom_range(0, 10);
      for (int w = 0; w < nw; w++) cpu_write(rand_addr(), 8'($urandom));
      run_frame($urandom_range(1, 35), rand_addr(), 8'($urandom),
                $urandom_range(1, 35), rand_addr(), 8'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
